fp32_to_int_conv: RTL and testbench

Pipelined IEEE-754 binary32 to integer converter with selectable rounding mode, signed/unsigned result, saturation and status flags. It is the synthesizable replacement for the simulation-only `real`-to-`integer` assignment in our number-format blocks. It sits between float-producing datapaths and fixed-width integer consumers on a valid/ready stream. Throughput is one conversion per clock and latency is 2 cycles.

---
 rtl/fp32_to_int_conv.sv | 148 ++++++++++++++
 tb/tb_fp32_to_int_conv.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_to_int_conv.sv
// fp32_to_int_conv: pipelined binary32 to integer converter with rounding modes, saturation and status flags
module fp32_to_int_conv #(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [1:0]       rnd_mode,
    input  logic             signed_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_inexact,
    output logic             out_nan
);
    localparam int               FW      = OUT_W + 24;
    localparam logic [7:0]       OVF_EXP = 8'(127 + OUT_W + 1);
    localparam logic [OUT_W+1:0] SMAX    = {3'b000, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W+1:0] SMIN    = {3'b001, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W+1:0] UMAX    = {2'b00, {OUT_W{1'b1}}};

    logic             en;
    logic             v0, v1;
    logic [31:0]      q_data;
    logic [1:0]       q_mode;
    logic             q_sgn;
    logic [7:0]       exp_f;
    logic [22:0]      frac;
    logic             is_nan, is_den, is_zexp, pre_ovf, tiny, half, kill;
    logic [7:0]       sh;
    logic [FW-1:0]    full;
    logic [OUT_W:0]   d_mag;
    logic             d_g, d_s;
    logic             s1_sign, s1_g, s1_s, s1_den, s1_povf, s1_nan, s1_sgn;
    logic [1:0]       s1_mode;
    logic [OUT_W:0]   s1_mag;
    logic             inc, big_p, big_n, r_ovf, r_inx;
    logic [OUT_W+1:0] rnd;
    logic [OUT_W-1:0] r_data;

    // The whole pipeline advances together unless a result is waiting on the consumer
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Valid bits for capture, aligned and output stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0        <= 1'b0;
            v1        <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            v0        <= in_valid;
            v1        <= v0;
            out_valid <= v1;
        end
    end

    // Capture the operand together with its own rounding mode and signedness
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_data <= '0;
            q_mode <= '0;
            q_sgn  <= 1'b0;
        end else if (en && in_valid) begin
            q_data <= in_data;
            q_mode <= rnd_mode;
            q_sgn  <= signed_out;
        end
    end

    // Classify and align the significand into integer magnitude, guard and sticky
    always_comb begin
        exp_f   = q_data[30:23];
        frac    = q_data[22:0];
        is_zexp = ~|exp_f;
        is_nan  = &exp_f & |frac;
        is_den  = is_zexp & |frac;
        pre_ovf = ~is_nan & (exp_f >= OVF_EXP);
        tiny    = exp_f < 8'd127;
        half    = exp_f == 8'd126;
        kill    = pre_ovf | is_nan | is_zexp;
        sh      = exp_f - 8'd127;
        full    = {{OUT_W{1'b0}}, 1'b1, frac} << sh;
        d_mag   = (kill | tiny) ? '0 : full[FW-1:23];
        d_g     = kill ? 1'b0 : tiny ? half : full[22];
        d_s     = kill ? 1'b0 : tiny ? (~half | |frac) : |full[21:0];
    end

    // Aligned-stage register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sign <= 1'b0;
            s1_mag  <= '0;
            s1_g    <= 1'b0;
            s1_s    <= 1'b0;
            s1_den  <= 1'b0;
            s1_povf <= 1'b0;
            s1_nan  <= 1'b0;
            s1_mode <= '0;
            s1_sgn  <= 1'b0;
        end else if (en && v0) begin
            s1_sign <= q_data[31];
            s1_mag  <= d_mag;
            s1_g    <= d_g;
            s1_s    <= d_s;
            s1_den  <= is_den;
            s1_povf <= pre_ovf;
            s1_nan  <= is_nan;
            s1_mode <= q_mode;
            s1_sgn  <= q_sgn;
        end
    end

    // Round the magnitude, apply the sign, then clamp to the selected range
    always_comb begin
        inc    = s1_mode == 2'd0 ? s1_g :
                 s1_mode == 2'd1 ? 1'b0 :
                 s1_mode == 2'd2 ? s1_sign & (s1_g | s1_s) :
                                   ~s1_sign & (s1_g | s1_s);
        rnd    = {1'b0, s1_mag} + {{(OUT_W+1){1'b0}}, inc};
        big_p  = s1_povf | (rnd > (s1_sgn ? SMAX : UMAX));
        big_n  = s1_povf | (s1_sgn ? (rnd > SMIN) : (rnd != '0));
        r_data = s1_nan  ? '0 :
                 ~s1_sign ? (big_p ? (s1_sgn ? {1'b0, {(OUT_W-1){1'b1}}} : {OUT_W{1'b1}}) : rnd[OUT_W-1:0]) :
                 ~s1_sgn  ? '0 :
                 big_n    ? {1'b1, {(OUT_W-1){1'b0}}} : '0 - rnd[OUT_W-1:0];
        r_ovf  = ~s1_nan & (s1_sign ? big_n : big_p);
        r_inx  = ~s1_nan & (s1_g | s1_s | s1_den);
    end

    // Output register holds result and flags until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data    <= '0;
            out_ovf     <= 1'b0;
            out_inexact <= 1'b0;
            out_nan     <= 1'b0;
        end else if (en && v1) begin
            out_data    <= r_data;
            out_ovf     <= r_ovf;
            out_inexact <= r_inx;
            out_nan     <= s1_nan;
        end
    end
endmodule

// File: tb/tb_fp32_to_int_conv.sv
// tb_fp32_to_int_conv: scoreboard bench for the binary32 to integer converter
module tb_fp32_to_int_conv;
    typedef struct packed {
        logic [31:0] f;
        logic [1:0]  m;
        logic        s;
        logic [31:0] d;
        logic        o;
        logic        x;
        logic        n;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, signed_out, out_valid, out_ready;
    logic        out_ovf, out_inexact, out_nan;
    logic [31:0] in_data, out_data;
    logic [1:0]  rnd_mode;
    logic        b_in_valid, b_in_ready, b_out_valid, b_ovf, b_inx, b_nan;
    logic        b_sgn, b_out_ready;
    logic [1:0]  b_mode;
    logic [31:0] b_in_data;
    logic [7:0]  b_out_data;

    vec_t        tbl[$];
    vec_t        w8[$];
    vec_t        sb[$];
    vec_t        sb8[$];
    vec_t        cur, cur8, e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        hold = 1'b0;
    logic [34:0] held;
    logic [3:0]  pat = 4'b1001;

    always #5 clk = ~clk;

    fp32_to_int_conv #(.OUT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rnd_mode(rnd_mode), .signed_out(signed_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .out_inexact(out_inexact), .out_nan(out_nan)
    );

    fp32_to_int_conv #(.OUT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .rnd_mode(b_mode), .signed_out(b_sgn), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ovf(b_ovf), .out_inexact(b_inx), .out_nan(b_nan)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on consume, check stability during stalls
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (in_valid && in_ready) sb.push_back(cur);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("spurious", 64'(sb.size()), 64'd1);
                else begin
                    e = sb.pop_front();
                    chk($sformatf("data_%h", e.f), 64'(out_data), 64'(e.d));
                    chk($sformatf("ovf_%h", e.f), 64'(out_ovf), 64'(e.o));
                    chk($sformatf("inexact_%h", e.f), 64'(out_inexact), 64'(e.x));
                    chk($sformatf("nan_%h", e.f), 64'(out_nan), 64'(e.n));
                end
            end
            if (out_valid && !out_ready) begin
                if (hold) chk("stall_hold", 64'({out_data, out_ovf, out_inexact, out_nan}), 64'(held));
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                held = {out_data, out_ovf, out_inexact, out_nan};
                hold = 1'b1;
            end else begin
                hold = 1'b0;
            end
            if (b_in_valid && b_in_ready) sb8.push_back(cur8);
            if (b_out_valid) begin
                if (sb8.size() == 0) chk("spurious8", 64'(sb8.size()), 64'd1);
                else begin
                    e = sb8.pop_front();
                    chk($sformatf("w8_data_%h", e.f), 64'(b_out_data), 64'(e.d));
                    chk($sformatf("w8_ovf_%h", e.f), 64'(b_ovf), 64'(e.o));
                    chk($sformatf("w8_inexact_%h", e.f), 64'(b_inx), 64'(e.x));
                    chk($sformatf("w8_nan_%h", e.f), 64'(b_nan), 64'(e.n));
                end
            end
        end
    end

    task automatic send(input vec_t v);
        int t = 0;
        cur = v;
        in_data = v.f;
        rnd_mode = v.m;
        signed_out = v.s;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send8(input vec_t v);
        cur8 = v;
        b_in_data = v.f;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1 b_in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || sb8.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain", 64'(sb.size() + sb8.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back('{32'h511502F9, 2'd0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{32'h40100000, 2'd0, 1'b1, 32'h00000002, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{32'h3F800000, 2'd0, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{32'h40200000, 2'd0, 1'b1, 32'h00000003, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{32'h40200000, 2'd1, 1'b1, 32'h00000002, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{32'h40200000, 2'd2, 1'b1, 32'h00000002, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{32'h40200000, 2'd3, 1'b1, 32'h00000003, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{32'hC0200000, 2'd0, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{32'hC0200000, 2'd1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{32'hC0200000, 2'd2, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{32'hC0200000, 2'd3, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{32'h7FC00000, 2'd0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{32'hFF800000, 2'd0, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{32'h00000001, 2'd3, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{32'hBF800000, 2'd0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{32'h00000000, 2'd0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{32'hBECCCCCD, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{32'h3F000000, 2'd0, 1'b1, 32'h00000001, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{32'h4F000000, 2'd0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{32'h4F000000, 2'd0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{32'hCF000000, 2'd0, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{32'h7F800000, 2'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0});
        w8.push_back('{32'h437F0000, 2'd0, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0});
        w8.push_back('{32'h437F8000, 2'd0, 1'b0, 32'h000000FF, 1'b1, 1'b1, 1'b0});
        w8.push_back('{32'h43800000, 2'd0, 1'b0, 32'h000000FF, 1'b1, 1'b0, 1'b0});

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        rnd_mode = '0;
        signed_out = 1'b1;
        out_ready = 1'b1;
        b_in_valid = 1'b0;
        b_in_data = '0;
        b_mode = 2'd0;
        b_sgn = 1'b0;
        b_out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_flags", 64'({out_ovf, out_inexact, out_nan}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        send(tbl[2]);
        @(negedge clk);
        chk("latency_edge_n", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_edge_n1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_edge_n2", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        foreach (tbl[i]) send(tbl[i]);
        drain();

        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk);
                    #1 out_ready = pat[i % 4];
                end
            end
            begin
                for (int i = 0; i < 8; i++) send(tbl[(i * 3) % tbl.size()]);
            end
        join
        out_ready = 1'b1;
        drain();

        @(posedge clk);
        #1;
        send(tbl[3]);
        send(tbl[7]);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        chk("midrst_flags", 64'({out_ovf, out_inexact, out_nan}), 64'd0);
        sb.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(out_valid), 64'd0);
        end

        @(posedge clk);
        #1;
        foreach (w8[i]) send8(w8[i]);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
